// File: rtl/sha256_result_checker_pkg.sv
// Shared constants for the SHA-256 result checker and the hash pipeline it follows.
// Also holds the hit comparison used on hash word 7.
package sha256_result_checker_pkg;

  localparam int SHA_WORD_W      = 32;
  localparam int SHA_HASH_W      = 256;
  localparam int DEFAULT_LATENCY = 67;

  typedef logic [SHA_WORD_W-1:0] sha_word_t;

  // A hash is golden when its top word does not exceed the target (unsigned).
  function automatic logic meets_target(input sha_word_t word7, input sha_word_t target);
    return (word7 <= target);
  endfunction

endpackage

// File: rtl/sha256_result_checker_golden_nonce_fifo.sv
// Synchronous FIFO for golden nonces with a valid/ready read side.
// Reports whether an offered push was accepted or dropped on a full FIFO.
module golden_nonce_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_accept,
  output logic         o_drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_pop;

  // Read handshake: the head entry leaves on any cycle where o_valid and
  // i_ready are both high; o_valid/o_data hold steady while i_ready is low.
  assign o_valid  = (r_count != '0);
  assign o_full   = (r_count == CW'(DEPTH));
  assign w_pop    = o_valid & i_ready;
  assign o_accept = i_push & (~o_full | w_pop);
  assign o_drop   = i_push & o_full & ~w_pop;
  assign o_data   = o_valid ? r_mem[r_rd] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (o_accept) r_wr <= r_wr + 1'b1;
      if (w_pop)    r_rd <= r_rd + 1'b1;
      case ({o_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (o_accept) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/sha256_result_checker.sv
// Pairs each issued nonce with the hash that returns LATENCY cycles later and
// queues nonces whose hash word 7 meets the target.
module sha256_result_checker
  import sha256_result_checker_pkg::*;
#(
  parameter int LATENCY    = DEFAULT_LATENCY,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SHA_WORD_W-1:0] rx_nonce,
  input  logic                  rx_issue,
  input  logic                  rx_new_work,
  input  logic [SHA_HASH_W-1:0] rx_hash,
  input  logic [SHA_WORD_W-1:0] rx_target,
  output logic [SHA_WORD_W-1:0] tx_nonce,
  output logic                  tx_valid,
  input  logic                  rx_ready,
  output logic                  tx_overflow,
  output logic [15:0]           tx_hits
);

  sha_word_t        r_tag_nonce [LATENCY];
  logic [LATENCY-1:0] r_tag_flag;
  logic             r_hit;
  sha_word_t        r_hit_nonce;
  logic             r_overflow;
  logic [15:0]      r_hits;
  logic             w_tag_flag;
  logic             w_accept;
  logic             w_drop;
  logic             w_full;
  logic             w_unused;

  assign w_unused = ^{rx_hash[SHA_HASH_W-SHA_WORD_W-1:0], w_full};

  // New work kills every in-flight flag, but a nonce issued alongside it belongs
  // to the new work and is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag_flag <= '0;
    end else if (rx_new_work) begin
      r_tag_flag <= {{(LATENCY-1){1'b0}}, rx_issue};
    end else begin
      r_tag_flag <= {r_tag_flag[LATENCY-2:0], rx_issue};
    end
  end

  always_ff @(posedge clk) begin
    r_tag_nonce[0] <= rx_nonce;
    for (int i = 1; i < LATENCY; i++) begin
      r_tag_nonce[i] <= r_tag_nonce[i-1];
    end
  end

  // The aligned result is stale too if new work lands on the cycle it emerges.
  assign w_tag_flag = r_tag_flag[LATENCY-1] & ~rx_new_work;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit <= 1'b0;
    end else begin
      r_hit <= w_tag_flag &
               meets_target(rx_hash[SHA_HASH_W-1 -: SHA_WORD_W], rx_target);
    end
  end

  always_ff @(posedge clk) begin
    r_hit_nonce <= r_tag_nonce[LATENCY-1];
  end

  golden_nonce_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (SHA_WORD_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .i_push   (r_hit),
    .i_data   (r_hit_nonce),
    .i_ready  (rx_ready),
    .o_valid  (tx_valid),
    .o_data   (tx_nonce),
    .o_full   (w_full),
    .o_accept (w_accept),
    .o_drop   (w_drop)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
      r_hits     <= '0;
    end else begin
      if (w_drop)   r_overflow <= 1'b1;
      if (w_accept) r_hits     <= r_hits + 1'b1;
    end
  end

  assign tx_overflow = r_overflow;
  assign tx_hits     = r_hits;

endmodule
